// File: rtl/frame_scanner.sv
// frame_scanner: raster-order pixel-query initiator.
// Issues (x_cord, y_cord) queries to a colour responder. Each returned colour
// arrives LATENCY clocks later and is forwarded to the VGA write port as one
// plot strobe. A LATENCY-deep pipe of {valid, x, y} carries each coordinate
// alongside its pending colour.
// Optional build macro AUTO_RESTART_EN: when defined, a completed frame goes
// straight back into a new scan at (0,0) instead of returning to idle.
module frame_scanner #(
  parameter int H_PIXELS = 320,
  parameter int V_PIXELS = 240,
  parameter int LATENCY  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic [8:0] x_cord,
  output logic [8:0] y_cord,
  input  logic [2:0] flag,
  output logic [8:0] vga_x,
  output logic [8:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam logic [8:0] X_LAST     = 9'(H_PIXELS - 1);
  localparam logic [8:0] Y_LAST     = 9'(V_PIXELS - 1);
  localparam logic [2:0] FLUSH_LAST = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [2:0] flush_q, flush_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] count_q, count_d;
  logic       push_valid_d;
  logic       pipe_clear_d;

  // Delay pipe: stage LATENCY-1 lines up with the responder's colour.
  logic       pv_q [LATENCY];
  logic [8:0] px_q [LATENCY];
  logic [8:0] py_q [LATENCY];

  // Next-state logic: raster walk, flush countdown, abort and frame completion.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    flush_d      = flush_q;
    done_d       = 1'b0;
    count_d      = count_q;
    push_valid_d = 1'b0;
    pipe_clear_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          x_d     = 9'd0;
          y_d     = 9'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (abort) begin
          state_d      = S_IDLE;
          x_d          = 9'd0;
          y_d          = 9'd0;
          pipe_clear_d = 1'b1;
        end else begin
          push_valid_d = 1'b1;
          if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
            // Last coordinate issued: hold it while the pipe drains.
            state_d = S_FLUSH;
            flush_d = 3'd0;
          end else if (x_q == X_LAST) begin
            x_d = 9'd0;
            y_d = y_q + 9'd1;
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
      S_FLUSH: begin
        if (abort) begin
          state_d      = S_IDLE;
          x_d          = 9'd0;
          y_d          = 9'd0;
          pipe_clear_d = 1'b1;
        end else if (flush_q == FLUSH_LAST) begin
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
          x_d     = 9'd0;
          y_d     = 9'd0;
`ifdef AUTO_RESTART_EN
          state_d = S_SCAN;
`else
          state_d = S_IDLE;
`endif
        end else begin
          flush_d = flush_q + 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        x_d     = 9'd0;
        y_d     = 9'd0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control registers: state, coordinates, flush counter and frame status.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= 9'd0;
      y_q     <= 9'd0;
      flush_q <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  // Coordinate delay pipe; an abort drops every pending entry at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        px_q[i] <= 9'd0;
        py_q[i] <= 9'd0;
      end
    end else if (pipe_clear_d) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv_q[i] <= 1'b0;
      end
    end else begin
      pv_q[0] <= push_valid_d;
      px_q[0] <= x_q;
      py_q[0] <= y_q;
      for (int i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        px_q[i] <= px_q[i-1];
        py_q[i] <= py_q[i-1];
      end
    end
  end

  assign x_cord      = x_q;
  assign y_cord      = y_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;
  assign plot        = pv_q[LATENCY-1];
  assign vga_x       = px_q[LATENCY-1];
  assign vga_y       = py_q[LATENCY-1];
  // The colour arrives from the responder in the plot cycle itself, so it is
  // forwarded straight through, masked to zero when no plot is pending.
  assign vga_colour  = pv_q[LATENCY-1] ? flag : 3'd0;

endmodule

// File: tb/tb_frame_scanner.sv
// Bench for frame_scanner: two instances (LATENCY 1 and 3, 4x3 frame) share
// start/abort/reset. Each has a delayed-colour responder. Expected outputs
// come from a frame-position model (cycles since the frame began).
module tb_frame_scanner;

  localparam int H = 4;
  localparam int V = 3;
  localparam int N = H * V;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, start, abort;
  logic [8:0] xc [2];
  logic [8:0] yc [2];
  logic [8:0] vx [2];
  logic [8:0] vy [2];
  logic [2:0] flg [2];
  logic [2:0] vc [2];
  logic       pl [2];
  logic       bz [2];
  logic       fd [2];
  logic [7:0] fc [2];

  frame_scanner #(.H_PIXELS(H), .V_PIXELS(V), .LATENCY(1)) dut0 (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .x_cord(xc[0]), .y_cord(yc[0]), .flag(flg[0]),
    .vga_x(vx[0]), .vga_y(vy[0]), .vga_colour(vc[0]), .plot(pl[0]),
    .busy(bz[0]), .frame_done(fd[0]), .frame_count(fc[0]));

  frame_scanner #(.H_PIXELS(H), .V_PIXELS(V), .LATENCY(3)) dut1 (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .x_cord(xc[1]), .y_cord(yc[1]), .flag(flg[1]),
    .vga_x(vx[1]), .vga_y(vy[1]), .vga_colour(vc[1]), .plot(pl[1]),
    .busy(bz[1]), .frame_done(fd[1]), .frame_count(fc[1]));

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic logic [2:0] colour_of(input int x, input int y);
    return 3'((x + 3 * y) % 8);
  endfunction

  // Responder for lane 0: colour registered once.
  logic [2:0] r0_q;
  always @(posedge clock) r0_q <= colour_of(int'(xc[0]), int'(yc[0]));
  assign flg[0] = r0_q;

  // Responder for lane 1: three-stage colour delay.
  logic [2:0] r1_q [3];
  always @(posedge clock) begin
    r1_q[0] <= colour_of(int'(xc[1]), int'(yc[1]));
    r1_q[1] <= r1_q[0];
    r1_q[2] <= r1_q[1];
  end
  assign flg[1] = r1_q[2];

  // Model state: is a frame in progress, and how many cycles since it began.
  bit m_valid, m_just_reset;
  bit m_active [2];
  int m_r [2];
  bit m_done [2];
  int m_count [2];

  int checks, errors, cyc, t0;
  int ev_first [2];
  int ev_last [2];
  int nplots [2];
  int ndone [2];
  int done_at [2][4];
  int base;

  task automatic chk(input string name, input int g, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s lane%0d cyc%0d got %0d expected %0d", name, g, cyc, act, exp);
    end
  endtask

  task automatic clear_rec();
    t0 = cyc;
    for (int g = 0; g < 2; g++) begin
      ev_first[g] = -1; ev_last[g] = -1; nplots[g] = 0; ndone[g] = 0;
      for (int k = 0; k < 4; k++) done_at[g][k] = -1;
    end
  endtask

  task automatic compare();
    for (int g = 0; g < 2; g++) begin
      int L = lat(g);
      int r = m_r[g];
      bit ep;
      int ex, ey;
      if (pl[g] === 1'b1) begin
        if (ev_first[g] < 0) ev_first[g] = cyc - t0;
        ev_last[g] = cyc - t0;
        nplots[g]++;
      end
      if (fd[g] === 1'b1) begin
        if (ndone[g] < 4) done_at[g][ndone[g]] = cyc - t0;
        ndone[g]++;
      end
      if (m_valid) begin
        ep = m_active[g] && (r >= L);
        if (m_active[g]) begin
          ex = (r < N) ? (r % H) : (H - 1);
          ey = (r < N) ? (r / H) : (V - 1);
        end else begin
          ex = 0; ey = 0;
        end
        chk("busy", g, int'(bz[g]), int'(m_active[g]));
        chk("plot", g, int'(pl[g]), int'(ep));
        chk("x_cord", g, int'(xc[g]), ex);
        chk("y_cord", g, int'(yc[g]), ey);
        chk("frame_done", g, int'(fd[g]), int'(m_done[g]));
        chk("frame_count", g, int'(fc[g]), m_count[g] % 256);
        if (ep) begin
          chk("vga_x", g, int'(vx[g]), (r - L) % H);
          chk("vga_y", g, int'(vy[g]), (r - L) / H);
          chk("vga_colour", g, int'(vc[g]), int'(colour_of((r - L) % H, (r - L) / H)));
        end
        if (m_just_reset) begin
          chk("vga_x_rst", g, int'(vx[g]), 0);
          chk("vga_y_rst", g, int'(vy[g]), 0);
          chk("vga_colour_rst", g, int'(vc[g]), 0);
        end
      end
    end
  endtask

  task automatic model_update(input bit st, input bit ab, input bit rs);
    if (rs) begin
      m_valid = 1'b1; m_just_reset = 1'b1;
      for (int g = 0; g < 2; g++) begin
        m_active[g] = 1'b0; m_r[g] = 0; m_done[g] = 1'b0; m_count[g] = 0;
      end
    end else begin
      m_just_reset = 1'b0;
      for (int g = 0; g < 2; g++) begin
        m_done[g] = 1'b0;
        if (m_active[g] && ab) begin
          m_active[g] = 1'b0;
        end else if (m_active[g]) begin
          m_r[g]++;
          if (m_r[g] == N + lat(g)) begin
            m_done[g] = 1'b1;
            m_count[g]++;
`ifdef AUTO_RESTART_EN
            m_r[g] = 0;
`else
            m_active[g] = 1'b0;
`endif
          end
        end else if (st) begin
          m_active[g] = 1'b1;
          m_r[g] = 0;
        end
      end
    end
  endtask

  task automatic step(input bit st, input bit ab, input bit rs);
    start = st; abort = ab; reset = rs;
    @(negedge clock);
    compare();
    @(posedge clock);
    model_update(st, ab, rs);
    cyc++;
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    m_valid = 1'b0; m_just_reset = 1'b0;
    for (int g = 0; g < 2; g++) begin
      m_active[g] = 1'b0; m_r[g] = 0; m_done[g] = 1'b0; m_count[g] = 0;
    end
    start = 1'b0; abort = 1'b0; reset = 1'b1;
    clear_rec();

    repeat (2) step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Single frame from one start pulse at t=0.
    clear_rec();
    step(1'b1, 1'b0, 1'b0);
`ifndef AUTO_RESTART_EN
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk("first_plot_t", 0, ev_first[0], 2);
    chk("last_plot_t", 0, ev_last[0], 13);
    chk("done_t", 0, done_at[0][0], 14);
    chk("plots", 0, nplots[0], 12);
    chk("dones", 0, ndone[0], 1);
    chk("first_plot_t", 1, ev_first[1], 4);
    chk("last_plot_t", 1, ev_last[1], 15);
    chk("done_t", 1, done_at[1][0], 16);
    chk("plots", 1, nplots[1], 12);
    chk("count_lit", 0, int'(fc[0]), 1);
`else
    repeat (46) step(1'b0, 1'b0, 1'b0);
    chk("done_t0", 0, done_at[0][0], 14);
    chk("done_t1", 0, done_at[0][1], 27);
    chk("done_t2", 0, done_at[0][2], 40);
    chk("done_t0", 1, done_at[1][0], 16);
    chk("done_t1", 1, done_at[1][1], 31);
    chk("done_t2", 1, done_at[1][2], 46);
    chk("count_lit", 0, int'(fc[0]), 3);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
`endif

    // Abort in the 5th scan cycle, then a fresh frame.
    base = int'(fc[0]);
    clear_rec();
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk("abort_dones", 0, ndone[0], 0);
    chk("abort_dones", 1, ndone[1], 0);
    chk("abort_plots", 0, nplots[0], 4);
    chk("abort_plots", 1, nplots[1], 2);
    chk("abort_count", 0, int'(fc[0]), base);
    clear_rec();
    step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
`ifndef AUTO_RESTART_EN
    chk("refill_plots", 0, nplots[0], 12);
    chk("refill_plots", 1, nplots[1], 12);
`endif
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Start held every cycle during a scan must not restart or queue.
    clear_rec();
    repeat (13) step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
`ifndef AUTO_RESTART_EN
    chk("start_spam_plots", 0, nplots[0], 12);
    chk("start_spam_dones", 0, ndone[0], 1);
    chk("start_spam_plots", 1, nplots[1], 12);
    chk("start_spam_dones", 1, ndone[1], 1);
`endif
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Reset during flush.
    clear_rec();
    step(1'b1, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    chk("rst_count", 0, int'(fc[0]), 0);
    chk("rst_count", 1, int'(fc[1]), 0);
    chk("rst_dones", 0, ndone[0], 0);
    chk("rst_dones", 1, ndone[1], 0);

    // Randomized start/abort/reset traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 8) == 0, ($urandom % 64) == 0, ($urandom % 500) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
